pwm_cfg_sequencer: RTL
======================

// Module: pwm_cfg_sequencer
// PURPOSE
//  Wishbone master that programs the PWM/timer register file safely from one
//  atomic configuration request: it takes a ctrl/divisor/period/duty set over a
//  valid/ready handshake and issues five ordered single writes.
//  Order: park CTRL, DIVISOR, PERIOD, DUTY, final CTRL.
//  It drives the PWM block's slave Wishbone port and reports done or error.
// PARAMETERS
//  TIMEOUT   64   max cycles STB may wait for ACK per write (>=2)
//  ADR_CTRL  0    CTRL register address
//  ADR_DIV   2    DIVISOR register address
//  ADR_PER   4    PERIOD register address
//  ADR_DUTY  6    DUTY register address
// PORTS
//  i_clk         in   1   system clock, rising edge
//  i_rst         in   1   asynchronous reset, active-low
//  i_cfg_valid   in   1   request valid
//  o_cfg_ready   out  1   high only in IDLE; accept = i_cfg_valid & o_cfg_ready
//  i_cfg_ctrl    in   16  final CTRL value
//  i_cfg_div     in   16  divisor
//  i_cfg_period  in   16  period
//  i_cfg_duty    in   16  duty
//  o_wb_cyc      out  1   Wishbone cycle
//  o_wb_stb      out  1   Wishbone strobe (always equal to o_wb_cyc)
//  o_wb_we       out  1   write enable (always equal to o_wb_cyc)
//  o_wb_adr      out  16  register address
//  o_wb_data     out  16  write data
//  i_wb_ack      in   1   slave acknowledge
//  o_busy        out  1   high from the cycle after accept until return to IDLE
//  o_done        out  1   1-cycle pulse: all five writes acknowledged
//  o_err         out  1   1-cycle pulse: request rejected or aborted
//  o_err_code    out  2   01 invalid cfg, 10 ACK timeout; held until next accept
// BEHAVIOUR
//  Reset (i_rst=0, async): state IDLE; all outputs 0 except o_cfg_ready=1.
//    Write index and timeout counter are cleared. Reset mid-write drops CYC at once.
//  On accept, all four cfg words are registered. Later input changes are ignored.
//  Validation runs on the registered copy in cycle 1 (state CHECK). The config is invalid if any of:
//    divisor==0;
//    period==0;
//    ctrl[1]=1 & ctrl[6]=0 & duty>period (unsigned 16-bit compare).
//    Invalid: o_err=1, o_err_code=01, no bus activity, then IDLE.
//  FSM: IDLE -> CHECK -> BUS -> (GAP -> BUS)x4 -> RESP -> IDLE.
//  Write table, indexed 0..4:
//    w0 ADR_CTRL, data (ctrl & 16'hFFE9) | 16'h0080: enables (bits 1,2,4) cleared, soft reset (bit7) set.
//    w1 ADR_DIV, divisor.
//    w2 ADR_PER, period.
//    w3 ADR_DUTY, duty.
//    w4 ADR_CTRL, data ctrl & 16'hFF7F: soft reset released.
//  BUS state: CYC/STB/WE=1, ADR/DATA from the table.
//    They are held stable until ACK is sampled high.
//    ACK on w0..w3 -> GAP (CYC=0 for exactly 1 cycle, index+1) -> BUS.
//    ACK on w4 -> RESP.
//  RESP: o_done=1, o_err_code=00 for one cycle -> IDLE.
//  ACK outside BUS is ignored. ACK in the first BUS cycle is legal (1-cycle write).
//  Timeout: the counter clears on entry to BUS and increments each BUS cycle without ACK.
//    At TIMEOUT cycles without ACK: CYC dropped next cycle, o_err=1, code=10, -> IDLE.
//    Earlier writes are not undone: w0 has already parked the core.
//  Latency with ACK in the 2nd BUS cycle: accept=cycle 0, CHECK=1, w0 STB cycles 2-3,
//    GAP 4, ... w4 STB cycles 14-15, o_done at cycle 16.
//    Minimum latency (ACK every 1st BUS cycle): o_done at cycle 11.
//  i_cfg_valid while busy: o_cfg_ready=0 and the request is not captured.
//    The next accept is possible in the cycle after the RESP or error pulse.
//  o_done and o_err are never high together.
// TESTING
//  1 Ctrl=0x0056, div=4, per=100, duty=25, slave ACKs in 2nd cycle -> writes
//    (0,0x00C0),(2,4),(4,100),(6,25),(0,0x0056) in order; o_done at cycle 16.
//  2 Duty=200, per=100, ctrl[1]=1, ctrl[6]=0 -> o_err pulse cycle 1, code 01, CYC never high.
//    Divisor=0 gives the same response.
//  3 Slave withholds ACK on w2 -> exactly 64 STB cycles, then CYC low.
//    Also o_err=1, code 10, o_cfg_ready=1 next cycle.
//  4 i_rst low during w3 BUS -> CYC/STB/busy drop immediately; after release,
//    a new request starts at w0.
//  5 i_cfg_valid held high and cfg words changed during a sequence -> the second
//    request is accepted only after o_done; the first sequence's data is unchanged.
//  6 Zero-wait slave (ACK combinational to STB) -> 1-cycle STB per write,
//    1-cycle GAP between writes, o_done at cycle 11.

Source files
------------

// File: rtl/pwm_cfg_sequencer.sv
// Wishbone master that programs the PWM register file from one
// atomic ctrl/divisor/period/duty request as five ordered writes.
module pwm_cfg_sequencer #(
  parameter int          TIMEOUT  = 64,
  parameter logic [15:0] ADR_CTRL = 16'd0,
  parameter logic [15:0] ADR_DIV  = 16'd2,
  parameter logic [15:0] ADR_PER  = 16'd4,
  parameter logic [15:0] ADR_DUTY = 16'd6
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cfg_valid,
  output logic        o_cfg_ready,
  input  logic [15:0] i_cfg_ctrl,
  input  logic [15:0] i_cfg_div,
  input  logic [15:0] i_cfg_period,
  input  logic [15:0] i_cfg_duty,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [15:0] o_wb_adr,
  output logic [15:0] o_wb_data,
  input  logic        i_wb_ack,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [1:0]  o_err_code
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_BUS,
    S_GAP,
    S_RESP,
    S_ERR
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_ctrl;
  logic [15:0] r_div;
  logic [15:0] r_per;
  logic [15:0] r_duty;
  logic [2:0]  r_idx;
  logic [CW-1:0] r_cnt;
  logic [1:0]  r_code;
  logic [1:0]  w_code;
  logic        w_accept;
  logic        w_invalid;
  logic [15:0] w_adr;
  logic [15:0] w_dat;

  assign w_accept = i_cfg_valid & o_cfg_ready;

  assign w_invalid = (r_div == 16'd0)
                   | (r_per == 16'd0)
                   | (r_ctrl[1] & ~r_ctrl[6]
                      & (r_duty > r_per));

  always_comb begin
    w_adr = 16'd0;
    w_dat = 16'd0;
    unique case (r_idx)
      3'd0: begin
        w_adr = ADR_CTRL;
        w_dat = (r_ctrl & 16'hFFE9) | 16'h0080;
      end
      3'd1: begin
        w_adr = ADR_DIV;
        w_dat = r_div;
      end
      3'd2: begin
        w_adr = ADR_PER;
        w_dat = r_per;
      end
      3'd3: begin
        w_adr = ADR_DUTY;
        w_dat = r_duty;
      end
      3'd4: begin
        w_adr = ADR_CTRL;
        w_dat = r_ctrl & 16'hFF7F;
      end
      default: begin
        w_adr = 16'd0;
        w_dat = 16'd0;
      end
    endcase
  end

  always_comb begin
    w_next      = r_state;
    w_code      = r_code;
    o_cfg_ready = 1'b0;
    o_wb_cyc    = 1'b0;
    o_done      = 1'b0;
    o_err       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        o_cfg_ready = 1'b1;
        if (i_cfg_valid) w_next = S_CHECK;
      end
      S_CHECK: begin
        if (w_invalid) begin
          o_err  = 1'b1;
          w_code = 2'b01;
          w_next = S_IDLE;
        end else begin
          w_next = S_BUS;
        end
      end
      S_BUS: begin
        o_wb_cyc = 1'b1;
        if (i_wb_ack)
          w_next = (r_idx == 3'd4) ? S_RESP : S_GAP;
        else if (r_cnt == CW'(TIMEOUT - 1))
          w_next = S_ERR;
      end
      S_GAP: w_next = S_BUS;
      S_RESP: begin
        o_done = 1'b1;
        w_code = 2'b00;
        w_next = S_IDLE;
      end
      S_ERR: begin
        o_err  = 1'b1;
        w_code = 2'b10;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign o_wb_stb   = o_wb_cyc;
  assign o_wb_we    = o_wb_cyc;
  assign o_wb_adr   = o_wb_cyc ? w_adr : 16'd0;
  assign o_wb_data  = o_wb_cyc ? w_dat : 16'd0;
  assign o_busy     = (r_state != S_IDLE);
  assign o_err_code = w_code;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= S_IDLE;
      r_ctrl  <= 16'd0;
      r_div   <= 16'd0;
      r_per   <= 16'd0;
      r_duty  <= 16'd0;
      r_idx   <= 3'd0;
      r_cnt   <= '0;
      r_code  <= 2'b00;
    end else begin
      r_state <= w_next;
      r_code  <= w_accept ? 2'b00 : w_code;
      if (w_accept) begin
        r_ctrl <= i_cfg_ctrl;
        r_div  <= i_cfg_div;
        r_per  <= i_cfg_period;
        r_duty <= i_cfg_duty;
      end
      if (r_state == S_IDLE)
        r_idx <= 3'd0;
      else if (r_state == S_GAP)
        r_idx <= r_idx + 3'd1;
      // counter restarts whenever BUS is (re)entered
      if (r_state != S_BUS)
        r_cnt <= '0;
      else if (!i_wb_ack)
        r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule
